// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: one shared shift/add/subtract
// datapath runs 32 iterations per operation; busy stalls the core meanwhile.
module mdu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result
);

    localparam int unsigned WORD = 32;
    localparam int unsigned CW   = 6;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [WORD-1:0]   a_q, b_q;
    logic [WORD-1:0]   opnd;
    logic [WORD-1:0]   hi, lo;
    logic [CW-1:0]     cnt;
    logic              neg_main, neg_rem, special;
    logic [WORD-1:0]   spec_res;

    logic              is_div, a_sgn, b_sgn, sa, sb, div0, ovf;
    logic [WORD-1:0]   mag_a, mag_b, spec_val;
    logic [WORD:0]     msum, dtry;
    logic              dge;
    logic [2*WORD-1:0] prod_fix;
    logic [WORD-1:0]   quo_fix, rem_fix, fix_val;

    // Operand signedness, magnitudes, special cases and one datapath step
    always_comb begin
        is_div   = op_q[2];
        a_sgn    = is_div ? ~op_q[0] : (op_q[1:0] != 2'b11);
        b_sgn    = is_div ? ~op_q[0] : ~op_q[1];
        sa       = a_sgn & a_q[WORD-1];
        sb       = b_sgn & b_q[WORD-1];
        mag_a    = sa ? -a_q : a_q;
        mag_b    = sb ? -b_q : b_q;
        div0     = is_div & (b_q == '0);
        ovf      = is_div & ~op_q[0] & (a_q == 32'h8000_0000) & (b_q == 32'hFFFF_FFFF);
        spec_val = '0;
        if (div0)
            spec_val = op_q[1] ? a_q : 32'hFFFF_FFFF;
        else if (ovf)
            spec_val = op_q[1] ? 32'h0 : 32'h8000_0000;

        // hi:lo is the accumulator/multiplier for MUL, remainder/quotient for DIV
        msum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
        dtry     = {hi, lo[WORD-1]};
        dge      = (dtry >= {1'b0, opnd});

        prod_fix = neg_main ? -{hi, lo} : {hi, lo};
        quo_fix  = neg_main ? -lo : lo;
        rem_fix  = neg_rem  ? -hi : hi;
        if (is_div)
            fix_val = op_q[1] ? rem_fix : quo_fix;
        else
            fix_val = (op_q[1:0] == 2'b00) ? prod_fix[WORD-1:0] : prod_fix[2*WORD-1:WORD];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            special  <= 1'b0;
            spec_res <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            result   <= '0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    neg_main <= sa ^ sb;
                    neg_rem  <= sa;
                    special  <= div0 | ovf;
                    spec_res <= spec_val;
                    hi       <= '0;
                    lo       <= is_div ? mag_a : mag_b;
                    opnd     <= is_div ? mag_b : mag_a;
                    cnt      <= '0;
                    state    <= (div0 | ovf) ? FIX : CALC;
                end
                CALC: begin
                    if (is_div) begin
                        hi <= dge ? WORD'(dtry - {1'b0, opnd}) : dtry[WORD-1:0];
                        lo <= {lo[WORD-2:0], dge};
                    end else begin
                        hi <= msum[WORD:1];
                        lo <= {msum[0], lo[WORD-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WORD - 1))
                        state <= FIX;
                end
                FIX: begin
                    result <= special ? spec_res : fix_val;
                    valid  <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: expected results queued at issue, compared on valid.
module tb_mdu_seq;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

    logic        clk, reset, start, abort, busy, valid;
    logic [2:0]  op;
    logic [31:0] a, b, result;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    mdu_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .abort(abort), .busy(busy), .valid(valid), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sp;
        logic        [63:0] up;
        logic signed [31:0] sx, sy;
        logic               ovf;
        sx  = x;
        sy  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            OP_MUL:    begin up = {32'b0, x} * {32'b0, y}; return up[31:0]; end
            OP_MULH:   begin sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return sp[63:32]; end
            OP_MULHSU: begin sp = $signed({{32{x[31]}}, x}) * $signed({32'b0, y}); return sp[63:32]; end
            OP_MULHU:  begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
            OP_DIV:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : sx / sy;
            OP_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            OP_REM:    return (y == 0) ? x : ovf ? 32'h0 : sx % sy;
            default:   return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 2;
        return 34;
    endfunction

    // Scoreboard monitor: every valid must match the oldest queued expectation
    always @(negedge clk) begin
        if (valid) begin
            if (exp_q.size() == 0) check("unexpected_valid", 32'(valid), 32'h0);
            else check("result", result, exp_q.pop_front());
        end
    end

    // Issue one op; poke adds ignored start pulses mid-operation and during valid
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] e, input int lat, input bit poke);
        int n, nbusy;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        n = -1; nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
            if (poke && n == 5) start = 1'b1;
            else if (poke && n == 6) start = 1'b0;
        end while (!valid && n < 60);
        check("latency", 32'(n), 32'(lat));
        check("busy_cycles", 32'(nbusy), 32'(lat + 1));
        if (poke) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_after", 32'(busy), 32'h0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry, prev;
        reset = 1'b1; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_result", result, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        run_op(OP_DIV,    32'd100,        32'd7,          32'd14,         34, 0);
        run_op(OP_REM,    32'd100,        32'd7,          32'd2,          34, 1);
        run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 0);
        run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 0);
        run_op(OP_REMU,   32'hFFFF_FFF9,  32'd2,          32'd1,          34, 0);
        run_op(OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  2,  0);
        run_op(OP_REM,    32'd5,          32'd0,          32'd5,          2,  1);
        run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2,  0);
        run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          2,  0);
        run_op(OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  34, 0);
        run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  34, 1);
        run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34, 0);
        run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34, 0);
        prev = 32'hFFFF_FFFE;

        // Abort in the 10th CALC cycle: no valid, result untouched
        @(negedge clk);
        op = OP_DIV; a = 32'd50; b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        repeat (10) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'h1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_valid", 32'(valid), 32'h0);
        check("abort_result", result, prev);
        repeat (40) @(negedge clk);
        check("abort_result_later", result, prev);

        // start together with abort in IDLE is not accepted
        @(negedge clk);
        op = OP_DIV; a = 32'd8; b = 32'd2; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'h0);
        repeat (40) @(negedge clk);
        check("start_abort_result", result, prev);

        // Async reset mid-CALC clears outputs before the next edge
        @(negedge clk);
        op = OP_DIV; a = 32'd9; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_result", result, 32'h0);
        @(negedge clk) reset = 1'b0;
        run_op(OP_DIV, 32'd9, 32'd3, 32'd3, 34, 0);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(ro, rx, ry, ref_mdu(ro, rx, ry), ref_lat(ro, rx, ry), i[0]);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
